// File: rtl/tile_framebuffer_if.sv
// rtl/tile_framebuffer_if.sv - tile write port and command port of the tile framebuffer
interface tile_framebuffer_if #(
    parameter int AW      = 10,
    parameter int COLOR_W = 8
);
    logic               wr_valid;
    logic               wr_ready;
    logic [AW-1:0]      wr_addr;
    logic [COLOR_W-1:0] wr_data;

    logic               clear_req;
    logic [COLOR_W-1:0] clear_color;
    logic               swap_req;
    logic               cmd_ready;
    logic               cmd_done;

    modport master (
        output wr_valid, wr_addr, wr_data, clear_req, clear_color, swap_req,
        input  wr_ready, cmd_ready, cmd_done
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clear_req, clear_color, swap_req,
        output wr_ready, cmd_ready, cmd_done
    );
endinterface

// File: rtl/tile_framebuffer.sv
// rtl/tile_framebuffer.sv - double-buffered tile framebuffer with clear/swap command FSM
module tile_framebuffer #(
    parameter int H_TILES   = 32,
    parameter int V_TILES   = 24,
    parameter int TILE_SIZE = 20,
    parameter int COLOR_W   = 8,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BG_COLOR  = 0,
    localparam int N        = H_TILES * V_TILES,
    localparam int AW       = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         hc,
    input  logic [9:0]         vc,
    output logic [AW-1:0]      pixel_addr,
    output logic [COLOR_W-1:0] color,
    output logic               pixel_active,
    output logic               front_bank,
    tile_framebuffer_if.slave  bus
);
    localparam logic [COLOR_W-1:0] BG = COLOR_W'(BG_COLOR);

    typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      clear_cnt;
    logic [COLOR_W-1:0] clear_val;
    logic               cmd_done_q, cmd_done_d;
    logic               toggle_front;

    logic [COLOR_W-1:0] bank0 [N];
    logic [COLOR_W-1:0] bank1 [N];

    logic               mem_we;
    logic [AW-1:0]      mem_waddr;
    logic [COLOR_W-1:0] mem_wdata;

    logic               act_d, act_q;
    logic [AW-1:0]      addr_d;
    int                 tile_lin;
    logic               at_boundary, boundary_q, frame_tick;
    logic [COLOR_W-1:0] front_word;

    // Stage 1: raster position to tile index; index parks at 0 in blanking.
    always_comb begin
        act_d    = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
        tile_lin = (int'(vc) / TILE_SIZE) * H_TILES + int'(hc) / TILE_SIZE;
        addr_d   = act_d ? AW'(tile_lin) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_addr <= '0;
            act_q      <= 1'b0;
        end else begin
            pixel_addr <= addr_d;
            act_q      <= act_d;
        end
    end

    assign front_word = front_bank ? bank1[pixel_addr] : bank0[pixel_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            color        <= BG;
            pixel_active <= 1'b0;
        end else begin
            color        <= act_q ? front_word : BG;
            pixel_active <= act_q;
        end
    end

    // One tick per frame: only the first cycle of the boundary position counts.
    assign at_boundary = (hc == 10'd0) && (int'(vc) == V_ACTIVE);
    assign frame_tick  = at_boundary && !boundary_q;

    always_comb begin
        state_d      = state_q;
        cmd_done_d   = 1'b0;
        toggle_front = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_req) begin
                    state_d = CLEAR;
                end else if (bus.swap_req) begin
                    state_d = SWAP_WAIT;
                end
            end
            CLEAR: begin
                if (clear_cnt == AW'(N - 1)) begin
                    state_d    = IDLE;
                    cmd_done_d = 1'b1;
                end
            end
            SWAP_WAIT: begin
                if (frame_tick) begin
                    state_d      = IDLE;
                    cmd_done_d   = 1'b1;
                    toggle_front = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.wr_ready  = (state_q == IDLE);
    assign bus.cmd_done  = cmd_done_q;

    // The clear owns the back bank while running; otherwise the write port does.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (state_q == CLEAR) begin
            mem_we    = !rst;
            mem_waddr = clear_cnt;
            mem_wdata = clear_val;
        end else if (state_q == IDLE && bus.wr_valid && (int'(bus.wr_addr) < N)) begin
            mem_we = !rst;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (front_bank) begin
                bank0[mem_waddr] <= mem_wdata;
            end else begin
                bank1[mem_waddr] <= mem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_done_q <= 1'b0;
            front_bank <= 1'b0;
            boundary_q <= 1'b0;
            clear_cnt  <= '0;
            clear_val  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_done_q <= cmd_done_d;
            boundary_q <= at_boundary;
            if (toggle_front) begin
                front_bank <= !front_bank;
            end
            if (state_q == IDLE && bus.clear_req) begin
                clear_cnt <= '0;
                clear_val <= bus.clear_color;
            end else if (state_q == CLEAR) begin
                clear_cnt <= clear_cnt + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_tile_framebuffer.sv
// tb/tb_tile_framebuffer.sv - self-checking bench for tile_framebuffer against a bank/tile model
module tb_tile_framebuffer;
    localparam int H_TILES   = 32;
    localparam int V_TILES   = 24;
    localparam int TILE_SIZE = 20;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int N         = H_TILES * V_TILES;
    localparam int AW        = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    hc, vc;
    logic [AW-1:0] pixel_addr;
    logic [7:0]    color;
    logic          pixel_active;
    logic          front_bank;

    tile_framebuffer_if #(.AW(AW), .COLOR_W(8)) bus ();

    tile_framebuffer #(
        .H_TILES(H_TILES), .V_TILES(V_TILES), .TILE_SIZE(TILE_SIZE), .COLOR_W(8),
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .BG_COLOR(0)
    ) dut (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc),
        .pixel_addr(pixel_addr), .color(color), .pixel_active(pixel_active),
        .front_bank(front_bank), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mdl [2][N];
    int mfront;
    int errors = 0;
    int checks = 0;

    typedef struct { int h; int v; int addr; bit act; } vec_t;
    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_active(int h, int v);
        return (h < H_ACTIVE) && (v < V_ACTIVE);
    endfunction

    function automatic int tile_of(int h, int v);
        return in_active(h, v) ? (v / TILE_SIZE) * H_TILES + h / TILE_SIZE : 0;
    endfunction

    function automatic logic [7:0] pix_color(int h, int v);
        return in_active(h, v) ? mdl[mfront][tile_of(h, v)] : 8'h00;
    endfunction

    task automatic read_px(input int h, input int v, input int eaddr, input bit eact);
        hc = 10'(h);
        vc = 10'(v);
        tick();
        check("pixel_addr", 32'(pixel_addr), eaddr);
        tick();
        check("pixel_active", 32'(pixel_active), 32'(eact));
        check("color", 32'(color), eact ? 32'(mdl[mfront][eaddr]) : 32'h0);
    endtask

    task automatic stream_line(input int v);
        for (int h = 0; h < H_ACTIVE + 2; h++) begin
            hc = 10'(h);
            vc = 10'(v);
            tick();
            check("stream_addr", 32'(pixel_addr), tile_of(h, v));
            if (h > 0) begin
                check("stream_color", 32'(color), 32'(pix_color(h - 1, v)));
                check("stream_active", 32'(pixel_active), 32'(in_active(h - 1, v)));
            end
        end
        hc = 10'd0;
        vc = 10'd0;
    endtask

    task automatic sweep_tiles();
        int h, v;
        for (int t = 0; t < N; t++) begin
            h = (t % H_TILES) * TILE_SIZE + int'($urandom_range(0, TILE_SIZE - 1));
            v = (t / H_TILES) * TILE_SIZE + int'($urandom_range(0, TILE_SIZE - 1));
            read_px(h, v, tile_of(h, v), in_active(h, v));
        end
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(a);
        bus.wr_data  = d;
        check("wr_ready_idle", 32'(bus.wr_ready), 1);
        tick();
        bus.wr_valid = 1'b0;
        if (a < N) mdl[1 - mfront][a] = d;
    endtask

    task automatic do_clear(input logic [7:0] c, input bit also_swap, input bit probe);
        int n;
        bus.clear_color = c;
        bus.clear_req   = 1'b1;
        bus.swap_req    = also_swap;
        if (probe) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(7);
            bus.wr_data  = 8'hEE;
            check("wr_ready_with_clear_req", 32'(bus.wr_ready), 1);
        end
        check("clear_accept_ready", 32'(bus.cmd_ready), 1);
        tick();
        bus.clear_req = 1'b0;
        bus.swap_req  = 1'b0;
        bus.wr_valid  = 1'b0;
        n = 0;
        while (bus.cmd_ready == 1'b0 && n < 2000) begin
            if (probe && n == 400) begin
                bus.wr_valid = 1'b1;
                bus.wr_addr  = AW'(5);
                bus.wr_data  = 8'hEE;
                check("wr_ready_during_clear", 32'(bus.wr_ready), 0);
            end else begin
                bus.wr_valid = 1'b0;
            end
            n++;
            tick();
        end
        bus.wr_valid = 1'b0;
        check("clear_busy_cycles", n, N);
        check("clear_done_pulse", 32'(bus.cmd_done), 1);
        for (int i = 0; i < N; i++) mdl[1 - mfront][i] = c;
        tick();
        check("clear_done_low", 32'(bus.cmd_done), 0);
    endtask

    task automatic do_swap(input int hold);
        int toggles, dones;
        logic prev;
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        check("swap_wait_ready", 32'(bus.cmd_ready), 0);
        check("swap_wait_front", 32'(front_bank), mfront);
        hc = 10'd0;
        vc = 10'(V_ACTIVE);
        toggles = 0;
        dones = 0;
        prev = front_bank;
        for (int k = 0; k < hold; k++) begin
            tick();
            if (front_bank != prev) toggles++;
            prev = front_bank;
            if (bus.cmd_done) dones++;
        end
        vc = 10'd0;
        tick();
        check("swap_toggles", toggles, 1);
        check("swap_dones", dones, 1);
        check("swap_done_low", 32'(bus.cmd_done), 0);
        mfront = 1 - mfront;
        check("swap_front", 32'(front_bank), mfront);
        check("swap_ready_after", 32'(bus.cmd_ready), 1);
    endtask

    initial begin
        int h, v, dones;

        tbl[0] = '{300,  20,  47, 1'b1};
        tbl[1] = '{299,  20,  46, 1'b1};
        tbl[2] = '{  0,   0,   0, 1'b1};
        tbl[3] = '{ 19,  19,   0, 1'b1};
        tbl[4] = '{ 20,  19,   1, 1'b1};
        tbl[5] = '{  0,  20,  32, 1'b1};
        tbl[6] = '{639, 479, 767, 1'b1};
        tbl[7] = '{640,  10,   0, 1'b0};
        tbl[8] = '{  5, 480,   0, 1'b0};
        tbl[9] = '{799, 524,   0, 1'b0};

        rst = 1'b1;
        hc = 10'd0;
        vc = 10'd0;
        bus.wr_valid = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = 8'h00;
        bus.clear_req = 1'b0;
        bus.clear_color = 8'h00;
        bus.swap_req = 1'b0;
        mfront = 0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_color", 32'(color), 0);
        check("rst_active", 32'(pixel_active), 0);
        check("rst_pixel_addr", 32'(pixel_addr), 0);
        check("rst_front", 32'(front_bank), 0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check("rst_cmd_done", 32'(bus.cmd_done), 0);
        check("rst_wr_ready", 32'(bus.wr_ready), 1);

        do_clear(8'h12, 1'b0, 1'b0);
        do_swap(1);
        sweep_tiles();
        stream_line(0);
        stream_line(239);
        stream_line(479);

        do_clear(8'h5A, 1'b0, 1'b0);
        do_write(47, 8'hFF);
        do_swap(5);
        for (int i = 0; i < 10; i++) read_px(tbl[i].h, tbl[i].v, tbl[i].addr, tbl[i].act);
        read_px(300, 20, 47, 1'b1);
        check("tile47_ff", 32'(color), 32'hFF);
        read_px(299, 20, 46, 1'b1);
        check("tile46_not_ff", 32'(color == 8'hFF), 0);

        do_clear(8'h3C, 1'b0, 1'b1);
        do_swap(1);
        read_px(5 * TILE_SIZE + 3, 10, 5, 1'b1);
        check("tile5_cleared", 32'(color), 32'h3C);
        read_px(7 * TILE_SIZE + 3, 10, 7, 1'b1);
        check("tile7_cleared", 32'(color), 32'h3C);
        do_write(800, 8'hAB);

        do_clear(8'h81, 1'b1, 1'b0);
        hc = 10'd0;
        vc = 10'(V_ACTIVE);
        tick();
        check("clr_swap_front", 32'(front_bank), mfront);
        check("clr_swap_done", 32'(bus.cmd_done), 0);
        check("clr_swap_ready", 32'(bus.cmd_ready), 1);
        vc = 10'd0;
        tick();

        hc = 10'd0;
        vc = 10'(V_ACTIVE);
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        check("tick_cycle_req_ready", 32'(bus.cmd_ready), 0);
        check("tick_cycle_req_front", 32'(front_bank), mfront);
        repeat (4) tick();
        check("tick_cycle_hold_front", 32'(front_bank), mfront);
        vc = 10'd0;
        tick();
        vc = 10'(V_ACTIVE);
        tick();
        mfront = 1 - mfront;
        check("next_tick_front", 32'(front_bank), mfront);
        check("next_tick_done", 32'(bus.cmd_done), 1);
        vc = 10'd0;
        tick();
        check("next_tick_ready", 32'(bus.cmd_ready), 1);
        stream_line(100);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 60; k++) do_write(int'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)));
            do_swap(int'($urandom_range(1, 3)));
            for (int k = 0; k < 40; k++) begin
                h = int'($urandom_range(0, 799));
                v = int'($urandom_range(0, 524));
                read_px(h, v, tile_of(h, v), in_active(h, v));
            end
            stream_line(int'($urandom_range(0, V_ACTIVE - 1)));
        end

        if (mfront != 0) do_swap(1);
        bus.clear_color = 8'h77;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (100) tick();
        check("clear_busy_before_rst", 32'(bus.cmd_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_clear_ready", 32'(bus.cmd_ready), 1);
        check("rst_mid_clear_done", 32'(bus.cmd_done), 0);
        check("rst_mid_clear_front", 32'(front_bank), 0);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.cmd_done) dones++;
        end
        check("rst_mid_clear_no_done", dones, 0);
        mfront = 0;
        stream_line(300);
        do_clear(8'h66, 1'b0, 1'b0);
        do_swap(2);
        stream_line(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/tile_framebuffer.md
Name: tile_framebuffer

Overview:
Parametrised, double-buffered tile framebuffer for the VGA path. Maps the raster position (hc, vc) to a tile index and returns that tile's colour through a registered 2-cycle read pipeline. Tile contents are writable at run time through a valid/ready port into the back bank. A command FSM provides a bulk clear of the back bank and a tear-free bank swap aligned to the start of vertical blanking.

Parameters:
H_TILES, 32, tiles per row
V_TILES, 24, tile rows
TILE_SIZE, 20, pixels per tile edge (square tiles)
COLOR_W, 8, colour width in bits
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines
BG_COLOR, 0, colour driven outside the active area
Derived: N = H_TILES*V_TILES; AW = $clog2(N)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
hc  in  10  horizontal raster counter
vc  in  10  vertical raster counter
pixel_addr  out  AW  tile index for the current pixel (stage-1 registered)
color  out  COLOR_W  pixel colour (stage-2 registered)
pixel_active  out  1  color is inside the active area (aligned with color)
wr_valid  in  1  tile write request
wr_ready  out  1  write port can accept
wr_addr  in  AW  tile index to write (back bank)
wr_data  in  COLOR_W  tile colour
clear_req  in  1  fill back bank with clear_color
clear_color  in  COLOR_W  fill value, sampled on acceptance
swap_req  in  1  exchange front/back banks at next frame boundary
cmd_ready  out  1  FSM idle; commands accepted
cmd_done  out  1  1-cycle pulse when a clear or swap completes
front_bank  out  1  bank currently displayed

Behaviour:
- Reset values: state IDLE, front_bank=0, color=BG_COLOR, pixel_active=0, pixel_addr=0, cmd_done=0. Memory contents are not reset. Reset mid-clear aborts the clear; partially cleared contents remain.
- Read pipeline:
  - Stage 1 registers addr = (vc/TILE_SIZE)*H_TILES + hc/TILE_SIZE and act = (hc<H_ACTIVE && vc<V_ACTIVE).
  - Stage 2 registers color = act_q ? front_mem[addr_q] : BG_COLOR, and pixel_active = act_q.
  - Latency is exactly 2 clk from hc/vc to color.
  - When act=0, pixel_addr holds 0.
- Banks: two N-entry arrays. Display reads only the front bank; writes and clears target only the back bank (~front_bank).
- Frame boundary: frame_tick = rising edge of (hc==0 && vc==V_ACTIVE), detected with one registered copy. At most one tick per frame regardless of pixel-clock rate.
- FSM states IDLE, CLEAR, SWAP_WAIT; cmd_ready = (state==IDLE).
  - IDLE: clear_req -> CLEAR (latch clear_color, count=0). Otherwise swap_req -> SWAP_WAIT. Simultaneous clear_req & swap_req: clear wins, swap dropped.
  - CLEAR: write clear_color to back[count] every cycle, count++. After count==N-1 is written -> IDLE with cmd_done=1. Takes exactly N cycles.
  - SWAP_WAIT: on frame_tick, toggle front_bank, pulse cmd_done, go to IDLE. If the request arrives in the same cycle as frame_tick, that tick is not used; the swap waits for the next one.
  - Requests outside IDLE are ignored (not queued).
- Write port:
  - wr_ready = (state==IDLE). A transfer occurs when wr_valid && wr_ready and writes back[wr_addr] = wr_data.
  - wr_addr >= N: the transfer is accepted and the data dropped.
  - A write accepted in the same cycle as clear_req lands first and is then overwritten by the clear.

Test Plan:
- Reset then idle: color=0, pixel_active=0, front_bank=0, cmd_ready=1.
- Clear and swap:
  - clear_req with clear_color=8'h12 -> cmd_ready low for exactly 768 cycles, then cmd_done pulse.
  - swap_req, then drive hc=0,vc=480 -> front_bank=1 and cmd_done on the tick.
  - Sweep hc=0..639, vc=0..479 -> every color=8'h12.
- Tile write and mapping:
  - Write tile 47 = 8'hFF to the back bank, then swap.
  - hc=300,vc=20 -> pixel_addr=47 after 1 cycle and color=8'hFF after 2 cycles.
  - hc=299,vc=20 (tile 46) -> color differs from 8'hFF.
- Blanking: hc=640,vc=10 and hc=5,vc=480 -> color=BG_COLOR, pixel_active=0 two cycles later.
- Handshake and boundaries:
  - During CLEAR, wr_valid=1 -> wr_ready=0 and memory unchanged.
  - wr_addr=800 -> accepted and ignored.
  - clear_req & swap_req together -> only the clear runs; front_bank unchanged.
- Swap timing:
  - swap_req asserted in the frame_tick cycle -> front_bank toggles only on the following frame's tick.
  - Holding hc=0,vc=480 for 5 cycles -> exactly one toggle.
  - Reset during CLEAR -> cmd_ready=1 next cycle, no cmd_done.
